// File: rtl/rf_wb_ctrl.sv
// Register-file write-back controller: clears x1..x(DEPTH-1) after reset, then
// arbitrates ALU and load-unit write-backs with alternating priority.
module rf_wb_ctrl #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_addr,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_ready,
  input  logic              mem_valid,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  output logic              mem_ready,
  output logic              rf_wr_en,
  output logic [ADDR_W-1:0] rf_wr_addr,
  output logic [DATA_W-1:0] rf_wr_data,
  output logic              init_busy,
  output logic [15:0]       wr_count
);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_ARB  = 1'b1
  } state_t;

  // Pointer is one bit wider so it can reach DEPTH when DEPTH == 2**ADDR_W.
  localparam logic [ADDR_W:0] PTR_FIRST = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0] PTR_END   = (ADDR_W+1)'(DEPTH);

  state_t              state_r, state_s;
  logic [ADDR_W:0]     ptr_r, ptr_s;
  logic                prio_mem_r, prio_mem_s;
  logic                wr_en_r, wr_en_s;
  logic [ADDR_W-1:0]   wr_addr_r, wr_addr_s;
  logic [DATA_W-1:0]   wr_data_r, wr_data_s;
  logic [15:0]         cnt_r, cnt_s;
  logic                alu_ready_s, mem_ready_s;
  logic [ADDR_W-1:0]   sel_addr_s;
  logic [DATA_W-1:0]   sel_data_s;

  // Grant decode: ready is a pure function of current valids and priority.
  always_comb begin
    alu_ready_s = 1'b0;
    mem_ready_s = 1'b0;
    if (!rst && (state_r == ST_ARB)) begin
      alu_ready_s = alu_valid & (~mem_valid | ~prio_mem_r);
      mem_ready_s = mem_valid & (~alu_valid | prio_mem_r);
    end else begin
      alu_ready_s = 1'b0;
      mem_ready_s = 1'b0;
    end
  end

  // Mux of the granted requester's payload.
  always_comb begin
    sel_addr_s = mem_addr;
    sel_data_s = mem_data;
    if (alu_ready_s) begin
      sel_addr_s = alu_addr;
      sel_data_s = alu_data;
    end else begin
      sel_addr_s = mem_addr;
      sel_data_s = mem_data;
    end
  end

  // Next-state and next-output logic for the clear/arbitrate FSM.
  always_comb begin
    state_s    = state_r;
    ptr_s      = ptr_r;
    prio_mem_s = prio_mem_r;
    wr_en_s    = 1'b0;
    wr_addr_s  = wr_addr_r;
    wr_data_s  = wr_data_r;
    cnt_s      = cnt_r;
    case (state_r)
      ST_INIT: begin
        if (ptr_r < PTR_END) begin
          wr_en_s   = 1'b1;
          wr_addr_s = ptr_r[ADDR_W-1:0];
          wr_data_s = {DATA_W{1'b0}};
          ptr_s     = ptr_r + PTR_FIRST;
        end else begin
          state_s = ST_ARB;
        end
      end
      ST_ARB: begin
        if (alu_ready_s || mem_ready_s) begin
          prio_mem_s = alu_ready_s;
          // x0 requests are acknowledged but never reach the register file.
          if (sel_addr_s != {ADDR_W{1'b0}}) begin
            wr_en_s   = 1'b1;
            wr_addr_s = sel_addr_s;
            wr_data_s = sel_data_s;
            if (cnt_r != 16'hFFFF) begin
              cnt_s = cnt_r + 16'd1;
            end else begin
              cnt_s = cnt_r;
            end
          end else begin
            wr_en_s = 1'b0;
          end
        end else begin
          prio_mem_s = prio_mem_r;
        end
      end
      default: begin
        state_s = ST_INIT;
        ptr_s   = PTR_FIRST;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_INIT;
      ptr_r      <= PTR_FIRST;
      prio_mem_r <= 1'b1;
      wr_en_r    <= 1'b0;
      wr_addr_r  <= {ADDR_W{1'b0}};
      wr_data_r  <= {DATA_W{1'b0}};
      cnt_r      <= 16'd0;
    end else begin
      state_r    <= state_s;
      ptr_r      <= ptr_s;
      prio_mem_r <= prio_mem_s;
      wr_en_r    <= wr_en_s;
      wr_addr_r  <= wr_addr_s;
      wr_data_r  <= wr_data_s;
      cnt_r      <= cnt_s;
    end
  end

  assign alu_ready  = alu_ready_s;
  assign mem_ready  = mem_ready_s;
  assign rf_wr_en   = wr_en_r;
  assign rf_wr_addr = wr_addr_r;
  assign rf_wr_data = wr_data_r;
  assign init_busy  = (state_r == ST_INIT);
  assign wr_count   = cnt_r;

endmodule

// File: tb/tb_rf_wb_ctrl.sv
// Randomized bench for rf_wb_ctrl against a queue-based behavioural model,
// plus directed sequences for clear, alternation, x0 drop, reset and saturation.
module tb_rf_wb_ctrl;
  localparam int AW    = 5;
  localparam int DW    = 32;
  localparam int DEPTH = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          alu_valid, mem_valid;
  logic [AW-1:0] alu_addr, mem_addr;
  logic [DW-1:0] alu_data, mem_data;
  logic          alu_ready, mem_ready;
  logic          rf_wr_en;
  logic [AW-1:0] rf_wr_addr;
  logic [DW-1:0] rf_wr_data;
  logic          init_busy;
  logic [15:0]   wr_count;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  rf_wb_ctrl #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_data(mem_data), .mem_ready(mem_ready),
    .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
    .init_busy(init_busy), .wr_count(wr_count)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: pending clear addresses, priority owner, last write, count.
  int            clr_q[$];
  bit            m_init;
  bit            m_prio_mem;
  int            m_cnt;
  bit            m_en;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  bit            last_ga, last_gm;

  function automatic bit exp_alu_rdy();
    return !rst && !m_init && alu_valid && (!mem_valid || !m_prio_mem);
  endfunction

  function automatic bit exp_mem_rdy();
    return !rst && !m_init && mem_valid && (!alu_valid || m_prio_mem);
  endfunction

  task automatic model_edge(input bit ga, input bit gm);
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    if (rst) begin
      clr_q.delete();
      for (int i = 1; i < DEPTH; i++) clr_q.push_back(i);
      m_init = 1'b1; m_prio_mem = 1'b1; m_cnt = 0;
      m_en = 1'b0; m_addr = '0; m_data = '0;
    end else if (m_init) begin
      if (clr_q.size() > 0) begin
        m_en = 1'b1; m_addr = AW'(clr_q.pop_front()); m_data = '0;
      end else begin
        m_init = 1'b0; m_en = 1'b0;
      end
    end else begin
      m_en = 1'b0;
      if (ga || gm) begin
        a = ga ? alu_addr : mem_addr;
        d = ga ? alu_data : mem_data;
        m_prio_mem = ga;
        if (a != 0) begin
          m_en = 1'b1; m_addr = a; m_data = d;
          if (m_cnt < 65535) m_cnt++;
        end
      end
    end
  endtask

  // One clock: inputs were set at the preceding negedge.
  task automatic cycle();
    bit ga, gm;
    #1;
    ga = exp_alu_rdy();
    gm = exp_mem_rdy();
    check_val("alu_ready", {63'd0, alu_ready}, {63'd0, ga});
    check_val("mem_ready", {63'd0, mem_ready}, {63'd0, gm});
    @(posedge clk);
    model_edge(ga, gm);
    #1;
    check_val("rf_wr_en",   {63'd0, rf_wr_en},  {63'd0, m_en});
    check_val("rf_wr_addr", 64'(rf_wr_addr),    64'(m_addr));
    check_val("rf_wr_data", 64'(rf_wr_data),    64'(m_data));
    check_val("init_busy",  {63'd0, init_busy}, {63'd0, m_init});
    check_val("wr_count",   64'(wr_count),      64'(m_cnt));
    last_ga = ga;
    last_gm = gm;
    @(negedge clk);
  endtask

  task automatic do_reset_and_clear();
    rst = 1'b1; alu_valid = 1'b0; mem_valid = 1'b0;
    cycle();
    rst = 1'b0;
    for (int i = 1; i < DEPTH; i++) begin
      cycle();
      check_val("clear_addr", 64'(rf_wr_addr), 64'(i));
    end
    cycle();
    check_val("init_done", {63'd0, init_busy}, 64'd0);
  endtask

  logic [AW-1:0] seq_addr [4];

  initial begin
    rst = 1'b1; alu_valid = 1'b0; mem_valid = 1'b0;
    alu_addr = '0; mem_addr = '0; alu_data = '0; mem_data = '0;

    // Reset state.
    cycle();
    check_val("rst_en",    {63'd0, rf_wr_en},  64'd0);
    check_val("rst_addr",  64'(rf_wr_addr),    64'd0);
    check_val("rst_data",  64'(rf_wr_data),    64'd0);
    check_val("rst_busy",  {63'd0, init_busy}, 64'd1);
    check_val("rst_count", 64'(wr_count),      64'd0);
    rst = 1'b0;
    for (int i = 1; i < DEPTH; i++) begin
      cycle();
      check_val("clear_en",   {63'd0, rf_wr_en}, 64'd1);
      check_val("clear_addr", 64'(rf_wr_addr),   64'(i));
    end
    cycle();
    check_val("init_done", {63'd0, init_busy}, 64'd0);

    // Both requesters held: MEM first, then alternating.
    alu_valid = 1'b1; alu_addr = 5'd3; alu_data = 32'hA3A3_0003;
    mem_valid = 1'b1; mem_addr = 5'd4; mem_data = 32'hB4B4_0004;
    for (int i = 0; i < 4; i++) begin
      cycle();
      check_val("both_ready", {63'd0, alu_ready & mem_ready}, 64'd0);
      seq_addr[i] = rf_wr_addr;
    end
    check_val("alt0", 64'(seq_addr[0]), 64'd4);
    check_val("alt1", 64'(seq_addr[1]), 64'd3);
    check_val("alt2", 64'(seq_addr[2]), 64'd4);
    check_val("alt3", 64'(seq_addr[3]), 64'd3);

    // Single ALU write.
    mem_valid = 1'b0; alu_addr = 5'd5; alu_data = 32'hDEAD_BEEF;
    cycle();
    alu_valid = 1'b0;
    check_val("alu_addr5", 64'(rf_wr_addr), 64'd5);
    check_val("alu_data",  64'(rf_wr_data), 64'hDEAD_BEEF);
    check_val("alu_count", 64'(wr_count),   64'd5);

    // x0 load is acknowledged and dropped.
    mem_valid = 1'b1; mem_addr = 5'd0; mem_data = 32'h1234;
    cycle();
    mem_valid = 1'b0;
    check_val("x0_en",    {63'd0, rf_wr_en}, 64'd0);
    check_val("x0_addr",  64'(rf_wr_addr),   64'd5);
    check_val("x0_count", 64'(wr_count),     64'd5);
    alu_valid = 1'b1; mem_valid = 1'b1; mem_addr = 5'd9; alu_addr = 5'd8;
    cycle();
    check_val("prio_alu", 64'(rf_wr_addr), 64'd8);
    alu_valid = 1'b0; mem_valid = 1'b0;
    cycle();

    // Reset pulse with a pending ALU request.
    alu_valid = 1'b1; alu_addr = 5'd7; alu_data = 32'h7777_7777;
    rst = 1'b1;
    cycle();
    rst = 1'b0; alu_valid = 1'b0;
    for (int i = 1; i < DEPTH; i++) begin
      cycle();
      check_val("reclear_addr", 64'(rf_wr_addr), 64'(i));
    end
    cycle();
    check_val("reclear_count", 64'(wr_count), 64'd0);

    // Randomized traffic, occasional resets.
    repeat (3000) begin
      rst = ($urandom_range(0, 299) == 0);
      if (!alu_valid && $urandom_range(0, 2) != 0) begin
        alu_valid = 1'b1;
        alu_addr  = ($urandom_range(0, 7) == 0) ? '0 : AW'($urandom);
        alu_data  = $urandom;
      end
      if (!mem_valid && $urandom_range(0, 2) != 0) begin
        mem_valid = 1'b1;
        mem_addr  = ($urandom_range(0, 7) == 0) ? '0 : AW'($urandom);
        mem_data  = $urandom;
      end
      cycle();
      if (last_ga) alu_valid = 1'b0;
      if (last_gm) mem_valid = 1'b0;
    end
    rst = 1'b0;

    // Saturation of the commit counter.
    do_reset_and_clear();
    alu_valid = 1'b1; alu_addr = 5'd1; alu_data = 32'h0BAD_F00D;
    repeat (65536) cycle();
    alu_valid = 1'b0;
    check_val("sat_count", 64'(wr_count), 64'hFFFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rf_wb_ctrl.md
RF_WB_CTRL -- requirements
Module: rf_wb_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 5, register address width.
REQ-002 SHALL have parameter DATA_W, default 32, register data width.
REQ-003 SHALL have parameter DEPTH, default 32, number of architectural registers (2..2^ADDR_W).
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have ports alu_valid input 1, alu_addr input ADDR_W, alu_data input DATA_W; ALU write-back request.
REQ-007 SHALL have port alu_ready  output  1  ALU request accepted this cycle when alu_valid=1.
REQ-008 SHALL have ports mem_valid input 1, mem_addr input ADDR_W, mem_data input DATA_W; load-unit write-back request.
REQ-009 SHALL have port mem_ready  output  1  load request accepted this cycle when mem_valid=1.
REQ-010 SHALL have ports rf_wr_en output 1, rf_wr_addr output ADDR_W, rf_wr_data output DATA_W; registered drive of the register-file write port.
REQ-011 SHALL have port init_busy  output  1  register-file clear sequence in progress.
REQ-012 SHALL have port wr_count  output 16  number of committed non-x0 writes since init completed.

Function
REQ-013 SHALL implement two states: INIT (clear register file) and ARB (arbitrate write-backs).
REQ-014 SHALL, in INIT, issue one write per cycle with rf_wr_data=0 to addresses 1..DEPTH-1 in ascending order; address 0 is never written.
REQ-015 SHALL present the first INIT write (addr 1) in the first cycle after rst deasserts, and the last (addr DEPTH-1) DEPTH-2 cycles later.
REQ-016 SHALL hold init_busy=1 from reset through the cycle presenting addr DEPTH-1, then enter ARB with init_busy=0.
REQ-017 SHALL hold alu_ready=0 and mem_ready=0 in INIT and whenever rst=1.
REQ-018 SHALL, in ARB, derive ready combinationally: alu_ready = alu_valid & (!mem_valid | prio==ALU); mem_ready = mem_valid & (!alu_valid | prio==MEM); never both high.
REQ-019 SHALL treat valid&ready at a rising edge as a handshake; at most one handshake per cycle.
REQ-020 SHALL set prio to the non-granted requester after every handshake; prio unchanged in cycles without handshake.
REQ-021 SHALL register the granted addr/data to rf_wr_addr/rf_wr_data, visible the cycle after the handshake (latency 1).
REQ-022 SHALL set rf_wr_en=1 the cycle after a handshake with addr!=0, and 0 otherwise; x0 requests complete the handshake but are dropped.
REQ-023 SHALL hold rf_wr_addr/rf_wr_data at their previous values in cycles with rf_wr_en=0.
REQ-024 SHALL increment wr_count on each cycle rf_wr_en=1 in ARB, saturating at 16'hFFFF; INIT writes are not counted.
REQ-025 SHALL require requesters to hold valid, addr and data stable until handshake; behaviour on violation is unspecified.

Reset
REQ-026 SHALL, on rst=1 at a rising edge, enter INIT, set init pointer to 1, prio=MEM, wr_count=0, rf_wr_en=0, rf_wr_addr=0, rf_wr_data=0, init_busy=1.
REQ-027 SHALL, on rst asserted mid-INIT or mid-ARB, abandon any pending request (not written) and restart the full clear sequence after rst deasserts.

Verification
REQ-028 Reset release, DEPTH=32 -> rf_wr_en=1 for 31 consecutive cycles, addrs 1..31, data 0; init_busy falls the following cycle; wr_count=0.
REQ-029 After init, alu_valid=1 addr=5 data=32'hDEAD_BEEF, mem_valid=0 -> alu_ready=1 same cycle; next cycle rf_wr_en=1, addr 5, data 32'hDEAD_BEEF; wr_count=1.
REQ-030 Both valid continuously (alu addr 3, mem addr 4) from first ARB cycle -> grants alternate MEM, ALU, MEM, ALU; rf_wr_addr sequence 4,3,4,3; never both ready.
REQ-031 mem_valid=1 addr=0 data=32'h1234 -> mem_ready=1; next cycle rf_wr_en=0, rf_wr_addr/data unchanged; wr_count unchanged; prio flips to ALU.
REQ-032 rst pulsed 1 cycle while alu_valid=1 in ARB -> alu_ready=0 during rst; no write of ALU data; clear sequence addr 1..31 restarts; wr_count=0.
REQ-033 Force wr_count to 16'hFFFF (65535 writes) then one more non-x0 write -> wr_count stays 16'hFFFF.
